// File: rtl/axis_rx_frame_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axis_rx_frame_arbiter_pkg
// Shared definitions for the frame-level AXI-Stream RX arbiter:
//   - arb_state_e   : two-state arbiter FSM encoding (IDLE / PASS)
//   - ARB_MAX_PORTS : largest supported number of requesting sources
//   - rr_candidate  : port visited at step k of a round-robin search
// ---------------------------------------------------------------------------
package axis_rx_frame_arbiter_pkg;

  localparam int ARB_MAX_PORTS = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_PASS = 1'b1
  } arb_state_e;

  // Port examined at search step k when the last winner was ptr:
  // ptr+1, ptr+2, ... wrapping modulo n.
  function automatic int rr_candidate(input int ptr, input int k, input int n);
    return (ptr + 1 + k) % n;
  endfunction

endpackage : axis_rx_frame_arbiter_pkg

// File: rtl/axis_rx_frame_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// axis_rx_frame_arbiter_rr_picker
// Combinational round-robin picker. Given a request vector and the index of
// the previous winner, returns a one-hot grant for the first requester found
// searching ptr+1, ptr+2, ... (mod NUM_PORTS). All-zero when nobody requests.
// Ports:
//   req_i  [NUM_PORTS]  request per port
//   ptr_i  [PTR_W]      index of the last granted port
//   gnt_o  [NUM_PORTS]  one-hot grant (0 when req_i == 0)
// ---------------------------------------------------------------------------
module axis_rx_frame_arbiter_rr_picker
  import axis_rx_frame_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  logic found;

  // Walk the priority order; the first requester met along the way wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!found && req_i[p] && (rr_candidate(int'(ptr_i), k, NUM_PORTS) == p)) begin
          gnt_o[p] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule : axis_rx_frame_arbiter_rr_picker

// File: rtl/axis_rx_frame_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rx_frame_arbiter
// Frame-level round-robin arbiter sharing one AXI-Stream sink between
// NUM_PORTS RX sources. A source is granted for a whole frame; the grant is
// released when its tlast beat is accepted, followed by one arbitration
// cycle. The output is a single registered stage; m_axis_tid carries the
// index of the source that produced each beat.
// Ports:
//   axis_clk, axis_a_rst_n   clock (rising edge), async active-low reset
//   enable_i                 1 = new grants allowed; 0 = finish frame, then idle
//   s_axis_t*                packed per-source AXI-Stream inputs
//   s_axis_tready            per-source ready, only the granted bit may be 1
//   m_axis_t*                registered AXI-Stream output with tid
//   grant_o                  one-hot current grant, 0 while idle
// ---------------------------------------------------------------------------
module axis_rx_frame_arbiter
  import axis_rx_frame_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS         = 2,
  parameter  int STREAM_DATA_WIDTH = 32,
  parameter  int ID_WIDTH          = 2,
  localparam int TKEEP_WIDTH       = STREAM_DATA_WIDTH / 8
) (
  input  logic                                   axis_clk,
  input  logic                                   axis_a_rst_n,
  input  logic                                   enable_i,
  input  logic [NUM_PORTS*STREAM_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*TKEEP_WIDTH-1:0]       s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]                   s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                   s_axis_tlast,
  output logic [NUM_PORTS-1:0]                   s_axis_tready,
  output logic [STREAM_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0]                 m_axis_tkeep,
  output logic                                   m_axis_tvalid,
  output logic                                   m_axis_tlast,
  output logic [ID_WIDTH-1:0]                    m_axis_tid,
  input  logic                                   m_axis_tready,
  output logic [NUM_PORTS-1:0]                   grant_o
);

  localparam int W  = STREAM_DATA_WIDTH;
  localparam int KW = TKEEP_WIDTH;

  // Illegal configurations stop elaboration.
  if (NUM_PORTS < 2 || NUM_PORTS > ARB_MAX_PORTS) begin : g_bad_num_ports
    $error("axis_rx_frame_arbiter: NUM_PORTS must be in 2..%0d", ARB_MAX_PORTS);
  end
  if (ID_WIDTH < $clog2(NUM_PORTS)) begin : g_bad_id_width
    $error("axis_rx_frame_arbiter: ID_WIDTH too small for NUM_PORTS");
  end
  if (W % 8 != 0 || W < 8) begin : g_bad_data_width
    $error("axis_rx_frame_arbiter: STREAM_DATA_WIDTH must be a non-zero multiple of 8");
  end

  // FSM / grant state
  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0]  gidx_q, gidx_d;
  logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;

  // Arbitration
  logic [NUM_PORTS-1:0] pick_gnt;
  logic [ID_WIDTH-1:0]  pick_idx;

  // Selected source beat
  logic [W-1:0]         in_data;
  logic [KW-1:0]        in_keep;
  logic                 in_valid;
  logic                 in_last;
  logic                 out_ready;
  logic                 in_accept;

  // Output register
  logic [W-1:0]         m_tdata_q, m_tdata_d;
  logic [KW-1:0]        m_tkeep_q, m_tkeep_d;
  logic                 m_tvalid_q, m_tvalid_d;
  logic                 m_tlast_q, m_tlast_d;
  logic [ID_WIDTH-1:0]  m_tid_q, m_tid_d;

  axis_rx_frame_arbiter_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (ID_WIDTH)
  ) u_picker (
    .req_i (s_axis_tvalid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt)
  );

  always_comb begin
    pick_idx = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pick_gnt[p]) pick_idx = ID_WIDTH'(p);
    end
  end

  // Per-port mux driven by the one-hot grant; all zero while idle.
  always_comb begin
    in_data  = '0;
    in_keep  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_q[p]) begin
        in_data  = s_axis_tdata[p*W +: W];
        in_keep  = s_axis_tkeep[p*KW +: KW];
        in_valid = s_axis_tvalid[p];
        in_last  = s_axis_tlast[p];
      end
    end
  end

  // The output stage can take a beat when empty or when it drains this cycle.
  assign out_ready     = !m_tvalid_q || m_axis_tready;
  assign in_accept     = (state_q == ARB_PASS) && in_valid && out_ready;
  assign s_axis_tready = ((state_q == ARB_PASS) && out_ready) ? grant_q : '0;

  // Next-state: grant taken in IDLE, released on the accepted tlast beat.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (enable_i && (|s_axis_tvalid)) begin
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          state_d = ARB_PASS;
        end
      end
      ARB_PASS: begin
        // A source dropping tvalid mid-frame keeps its grant indefinitely.
        if (in_accept && in_last) begin
          rr_ptr_d = gidx_q;
          grant_d  = '0;
          state_d  = ARB_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Output register: load on acceptance, otherwise drain when the sink is ready.
  always_comb begin
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tlast_d  = m_tlast_q;
    m_tid_d    = m_tid_q;
    m_tvalid_d = m_tvalid_q;
    if (in_accept) begin
      m_tdata_d  = in_data;
      m_tkeep_d  = in_keep;
      m_tlast_d  = in_last;
      m_tid_d    = gidx_q;
      m_tvalid_d = 1'b1;
    end else if (m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  // rr_ptr resets to the last port so that port 0 is searched first.
  always_ff @(posedge axis_clk or negedge axis_a_rst_n) begin
    if (!axis_a_rst_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= ID_WIDTH'(NUM_PORTS - 1);
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tid_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      m_tdata_q  <= m_tdata_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tid_q    <= m_tid_d;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tid    = m_tid_q;
  assign grant_o       = grant_q;

endmodule : axis_rx_frame_arbiter

// File: tb/tb_axis_rx_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_rx_frame_arbiter
// Directed reset / latency / async-reset checks followed by randomized
// multi-source traffic with backpressure, valid gaps and enable toggling.
// The reference model holds every source frame in arrays and predicts the
// output frame order from the round-robin rule over sources with frames left.
// ---------------------------------------------------------------------------
module tb_axis_rx_frame_arbiter;

  localparam int NP   = 3;
  localparam int W    = 32;
  localparam int KW   = W / 8;
  localparam int IDW  = 2;
  localparam int NF   = 6;
  localparam int MAXB = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [NP*W-1:0]   s_tdata;
  logic [NP*KW-1:0]  s_tkeep;
  logic [NP-1:0]     s_tvalid;
  logic [NP-1:0]     s_tlast;
  logic [NP-1:0]     s_tready;
  logic [W-1:0]      m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tvalid;
  logic              m_tlast;
  logic [IDW-1:0]    m_tid;
  logic              m_tready;
  logic [NP-1:0]     grant;

  always #5 clk = ~clk;

  axis_rx_frame_arbiter #(
    .NUM_PORTS         (NP),
    .STREAM_DATA_WIDTH (W),
    .ID_WIDTH          (IDW)
  ) dut (
    .axis_clk      (clk),
    .axis_a_rst_n  (rst_n),
    .enable_i      (enable),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tid    (m_tid),
    .m_axis_tready (m_tready),
    .grant_o       (grant)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive_port(input int p, input logic v, input logic [W-1:0] d,
                            input logic [KW-1:0] k, input logic l);
    s_tvalid[p]        = v;
    s_tdata[p*W +: W]  = d;
    s_tkeep[p*KW +: KW] = k;
    s_tlast[p]         = l;
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < NP; p++) drive_port(p, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_tvalid"}, m_tvalid, 0);
    check_eq({tag, "_tlast"},  m_tlast,  0);
    check_eq({tag, "_tdata"},  m_tdata,  0);
    check_eq({tag, "_tkeep"},  m_tkeep,  0);
    check_eq({tag, "_tid"},    m_tid,    0);
    check_eq({tag, "_sready"}, s_tready, 0);
    check_eq({tag, "_grant"},  grant,    0);
  endtask

  // Reference frames and model state
  int             flen [NP][NF];
  logic [W-1:0]   fdat [NP][NF][MAXB];
  logic [KW-1:0]  fkeep[NP][NF][MAXB];
  int             fi[NP], bi[NP];      // source-side progress
  int             ofi[NP];             // frames fully seen at the sink, per port
  int             ob, cur, last_tid, exp_tid;
  int             in_beats, out_beats, cycles;
  logic           done;
  logic [NP-1:0]  prev_grant;
  logic           prev_en, prev_stall;
  logic [W-1:0]   prev_data;
  logic [KW-1:0]  prev_keep;
  logic           prev_last;
  logic [IDW-1:0] prev_tid;
  int             beat;

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b1;
    m_tready = 1'b1;
    idle_inputs();

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- latency and first grant (port 0) ----------------
    beat = 0;
    for (int c = 0; c < 5; c++) begin
      drive_port(0, 1'b1, 32'hA000_0000 + beat, 4'hF, 1'b0);
      #1;
      if (c == 0) begin
        check_eq("lat_grant_c0", grant, 0);
        check_eq("lat_mvalid_c0", m_tvalid, 0);
      end
      if (c == 1) begin
        check_eq("lat_grant_c1", grant, 3'b001);
        check_eq("lat_sready_c1", s_tready, 3'b001);
        check_eq("lat_mvalid_c1", m_tvalid, 0);
      end
      if (c >= 2) begin
        check_eq("lat_mvalid", m_tvalid, 1);
        check_eq("lat_mdata", m_tdata, 32'hA000_0000 + (c - 2));
        check_eq("lat_tid", m_tid, 0);
      end
      if (s_tready[0]) beat++;
      @(negedge clk);
    end
    check_eq("lat_beats_accepted", beat, 4);

    // ---------------- asynchronous reset mid-frame ----------------
    drive_port(0, 1'b1, 32'hA000_0000 + beat, 4'hF, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive_port(0, 1'b1, 32'hB000_0000, 4'hF, 1'b0);
    drive_port(1, 1'b1, 32'hC000_0000, 4'hF, 1'b0);
    #1;
    check_eq("post_rst_idle", grant, 0);
    @(negedge clk);
    #1;
    check_eq("post_rst_winner", grant, 3'b001);
    check_eq("post_rst_sready", s_tready, 3'b001);

    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ---------------- randomized multi-source traffic ----------------
    for (int p = 0; p < NP; p++) begin
      for (int f = 0; f < NF; f++) begin
        flen[p][f] = (f == 0) ? 1 : 1 + int'($urandom % MAXB);
        for (int b = 0; b < MAXB; b++) begin
          fdat[p][f][b]  = $urandom;
          fkeep[p][f][b] = KW'($urandom_range(1, 15));
        end
      end
      fi[p] = 0; bi[p] = 0; ofi[p] = 0;
    end
    ob = 0; cur = 0; last_tid = NP - 1;
    in_beats = 0; out_beats = 0; cycles = 0; done = 1'b0;
    prev_grant = '0; prev_en = 1'b1; prev_stall = 1'b0;
    prev_data = '0; prev_keep = '0; prev_last = 1'b0; prev_tid = '0;

    @(negedge clk);
    while (!done && cycles < 20000) begin
      enable   = ($urandom % 6) != 0;
      m_tready = ($urandom % 3) != 0;
      for (int p = 0; p < NP; p++) begin
        if (fi[p] < NF) begin
          // First beat of a frame is always offered; later beats may gap.
          drive_port(p, (bi[p] == 0) ? 1'b1 : (($urandom % 4) != 0),
                     fdat[p][fi[p]][bi[p]], fkeep[p][fi[p]][bi[p]],
                     bi[p] == flen[p][fi[p]] - 1);
        end else begin
          drive_port(p, 1'b0, '0, '0, 1'b0);
        end
      end
      #1;

      check_eq("ready_outside_grant", s_tready & ~grant, 0);
      check_eq("grant_onehot0", $onehot0(grant), 1);
      if (prev_grant == 0 && grant != 0) check_eq("grant_while_disabled", prev_en, 1);
      if (prev_stall) begin
        check_eq("stall_valid", m_tvalid, 1);
        check_eq("stall_data", m_tdata, prev_data);
        check_eq("stall_keep", m_tkeep, prev_keep);
        check_eq("stall_last", m_tlast, prev_last);
        check_eq("stall_tid", m_tid, prev_tid);
      end

      for (int p = 0; p < NP; p++) begin
        if (s_tvalid[p] && s_tready[p]) begin
          in_beats++;
          bi[p]++;
          if (bi[p] == flen[p][fi[p]]) begin
            bi[p] = 0;
            fi[p]++;
          end
        end
      end

      if (m_tvalid && m_tready) begin
        out_beats++;
        if (ob == 0) begin
          exp_tid = -1;
          for (int k = 1; k <= NP; k++) begin
            if (exp_tid < 0 && ofi[(last_tid + k) % NP] < NF) exp_tid = (last_tid + k) % NP;
          end
          check_eq("frame_order_tid", m_tid, exp_tid);
          cur = (exp_tid < 0) ? 0 : exp_tid;
        end
        if (ofi[cur] >= NF) begin
          check_eq("beat_beyond_frames", 64'(ofi[cur]), 64'(NF - 1));
        end else begin
          check_eq("beat_tid", m_tid, cur);
          check_eq("beat_data", m_tdata, fdat[cur][ofi[cur]][ob]);
          check_eq("beat_keep", m_tkeep, fkeep[cur][ofi[cur]][ob]);
          check_eq("beat_last", m_tlast, ob == flen[cur][ofi[cur]] - 1);
          ob++;
          if (ob == flen[cur][ofi[cur]]) begin
            ob = 0;
            ofi[cur]++;
            last_tid = cur;
          end
        end
      end

      done = 1'b1;
      for (int p = 0; p < NP; p++) if (ofi[p] < NF) done = 1'b0;

      prev_grant = grant;
      prev_en    = enable;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_keep  = m_tkeep;
      prev_last  = m_tlast;
      prev_tid   = m_tid;
      cycles++;
      @(negedge clk);
    end

    check_eq("all_frames_delivered", done, 1);
    check_eq("beat_count_in_vs_out", in_beats, out_beats);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_axis_rx_frame_arbiter
